nbit_add: RTL and testbench

Parameterised N-bit ripple-carry adder with a registered output stage. Each bit is one full-adder cell, and the carry chains from bit 0 to bit BITS-1. The per-bit carry-out vector is exported alongside the sum, so downstream logic can tap any intermediate carry. It sits in the datapath as a single-cycle arithmetic stage between operand registers and the consumer.

---
 rtl/nbit_add_pkg.sv | 32 +++
 rtl/full_adder.sv | 16 +
 rtl/nbit_add.sv | 84 ++++++++
 tb/tb_nbit_add.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nbit_add_pkg.sv
// Shared constants and reference arithmetic for the nbit_add ripple-carry adder.
package nbit_add_pkg;

  localparam int unsigned NBIT_ADD_DEFAULT_BITS = 7;
  localparam int unsigned NBIT_ADD_MAX_BITS     = 64;

  typedef struct packed {
    logic [NBIT_ADD_MAX_BITS-1:0] c;
    logic [NBIT_ADD_MAX_BITS-1:0] s;
  } add_res_t;

  // c[i] is the carry out of the truncated sum a[i:0] + b[i:0] + cin; bits >= `bits` stay zero.
  function automatic add_res_t ref_add(input int unsigned bits,
                                       input logic [NBIT_ADD_MAX_BITS-1:0] a,
                                       input logic [NBIT_ADD_MAX_BITS-1:0] b,
                                       input logic cin);
    add_res_t                   res;
    logic [NBIT_ADD_MAX_BITS:0] part;
    logic [NBIT_ADD_MAX_BITS-1:0] mask;
    res = '0;
    for (int unsigned i = 0; i < NBIT_ADD_MAX_BITS; i++) begin
      if (i < bits) begin
        mask     = {NBIT_ADD_MAX_BITS{1'b1}} >> (NBIT_ADD_MAX_BITS - 1 - i);
        part     = {1'b0, a & mask} + {1'b0, b & mask} + {{NBIT_ADD_MAX_BITS{1'b0}}, cin};
        res.c[i] = part[i+1];
        res.s[i] = part[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell; one instance per bit of the nbit_add carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/nbit_add.sv
// BITS-wide ripple-carry adder with registered sum, per-bit carries and valid.
// Optional signed-overflow output is enabled with the NBIT_ADD_OVF_EN macro.
module nbit_add
  import nbit_add_pkg::*;
#(
  parameter int unsigned BITS = NBIT_ADD_DEFAULT_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] s,
  output logic [BITS-1:0] c,
`ifdef NBIT_ADD_OVF_EN
  output logic            ovf,
`endif
  output logic            out_valid
);

  logic [BITS:0]   w_k;
  logic [BITS-1:0] w_s;
  logic [BITS-1:0] w_c;

  logic [BITS-1:0] r_s;
  logic [BITS-1:0] r_c;
  logic            r_out_valid;

  assign w_k[0] = cin;

  for (genvar gi = 0; gi < BITS; gi++) begin : g_fa
    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (w_k[gi]),
      .s    (w_s[gi]),
      .cout (w_k[gi+1])
    );
  end

  assign w_c = w_k[BITS:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s <= w_s;
        r_c <= w_c;
      end
    end
  end

`ifdef NBIT_ADD_OVF_EN
  logic r_ovf;

  // Two's-complement overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_c[BITS-1] ^ w_c[BITS-2];
    end
  end

  assign ovf = r_ovf;
`endif

  assign s         = r_s;
  assign c         = r_c;
  assign out_valid = r_out_valid;

  add_res_t w_ref;

  assign w_ref = ref_add(BITS, NBIT_ADD_MAX_BITS'(a), NBIT_ADD_MAX_BITS'(b), cin);

  a_chain_matches_ref : assert property (@(posedge clk)
    w_ref == {NBIT_ADD_MAX_BITS'(w_c), NBIT_ADD_MAX_BITS'(w_s)});

endmodule

// File: tb/tb_nbit_add.sv
// Self-checking bench for nbit_add (BITS=7): directed vector table, hand-written
// hold/reset sequences and randomized traffic against an arithmetic model.
module tb_nbit_add;

  localparam int W = 7;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic [W-1:0] c;
  logic         out_valid;
  logic         ovf;

  int checks;
  int errors;

  nbit_add #(
    .BITS (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .c         (c),
`ifdef NBIT_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

`ifndef NBIT_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic rn, input logic v, input logic [W-1:0] ta,
                      input logic [W-1:0] tb, input logic tc);
    rst_n    = rn;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] m_sum(input int ia, input int ib, input int ic);
    return W'((ia + ib + ic) % (1 << W));
  endfunction

  // Carry out of bit i is whether the low (i+1)-bit partial sum overflows.
  function automatic logic [W-1:0] m_carry(input int ia, input int ib, input int ic);
    logic [W-1:0] cv;
    for (int i = 0; i < W; i++) begin
      int m;
      m     = 1 << (i + 1);
      cv[i] = ((ia % m) + (ib % m) + ic) >= m;
    end
    return cv;
  endfunction

  function automatic logic m_ovf(input int ia, input int ib, input int ic);
    int sa;
    int sb;
    int r;
    sa = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
    sb = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
    r  = sa + sb + ic;
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] es, input logic [W-1:0] ec,
                              input logic eo, input logic ev);
    check({tag, ".s"}, 32'(s), 32'(es));
    check({tag, ".c"}, 32'(c), 32'(ec));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
`ifdef NBIT_ADD_OVF_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unreachable");
`endif
  endtask

  initial begin
    logic [W-1:0] hs;
    logic [W-1:0] hc;
    logic         ho;
    checks = 0;
    errors = 0;

    vecs[0] = '{7'b1011011, 7'b0101011, 1'b0, 7'b0000110, 7'b1111011, 1'b0};
    vecs[1] = '{7'b1111111, 7'b0000000, 1'b1, 7'b0000000, 7'b1111111, 1'b0};
    vecs[2] = '{7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 7'b0000000, 1'b0};
    vecs[3] = '{7'b0111111, 7'b0000001, 1'b0, 7'b1000000, 7'b0111111, 1'b1};
    vecs[4] = '{7'b1111111, 7'b0000001, 1'b0, 7'b0000000, 7'b1111111, 1'b0};
    vecs[5] = '{7'b1000000, 7'b1000000, 1'b1, 7'b0000001, 7'b1000000, 1'b1};

    // Reset applies regardless of in_valid.
    step(1'b0, 1'b1, 7'b1011011, 7'b0101011, 1'b1);
    step(1'b0, 1'b1, 7'b1111111, 7'b1111111, 1'b1);
    check_result("reset", '0, '0, 1'b0, 1'b0);

    // Directed table, back-to-back.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      check_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].ovf, 1'b1);
    end

    // One-cycle pulse, then hold with changed operands.
    step(1'b1, 1'b1, vecs[0].a, vecs[0].b, vecs[0].cin);
    check_result("pulse", vecs[0].s, vecs[0].c, vecs[0].ovf, 1'b1);
    step(1'b1, 1'b0, 7'b0111111, 7'b0000001, 1'b1);
    check_result("hold1", vecs[0].s, vecs[0].c, vecs[0].ovf, 1'b0);
    step(1'b1, 1'b0, 7'b1111111, 7'b1111111, 1'b0);
    check_result("hold2", vecs[0].s, vecs[0].c, vecs[0].ovf, 1'b0);

    // Mid-stream reset drops the in-flight operation.
    step(1'b1, 1'b1, vecs[3].a, vecs[3].b, vecs[3].cin);
    step(1'b0, 1'b1, 7'b1011011, 7'b0101011, 1'b0);
    check_result("midrst", '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 7'b1011011, 7'b0101011, 1'b0);
    check_result("dropped", '0, '0, 1'b0, 1'b0);

    // First edge out of reset accepts an operation.
    step(1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b1, vecs[1].a, vecs[1].b, vecs[1].cin);
    check_result("first", vecs[1].s, vecs[1].c, vecs[1].ovf, 1'b1);

    // Randomized traffic against the arithmetic model.
    hs = vecs[1].s;
    hc = vecs[1].c;
    ho = vecs[1].ovf;
    for (int n = 0; n < 300; n++) begin
      int ra;
      int rb;
      int rc;
      logic rv;
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      rc = int'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      step(1'b1, rv, W'(ra), W'(rb), rc[0]);
      if (rv) begin
        hs = m_sum(ra, rb, rc);
        hc = m_carry(ra, rb, rc);
        ho = m_ovf(ra, rb, rc);
      end
      check_result($sformatf("rand%0d", n), hs, hc, ho, rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
